// File: rtl/refill_arbiter.sv
// Round-robin arbiter that serves I-cache (id 0) and D-cache (id 1) line refills.
// Each refill is four single-word reads from main memory, issued one at a time.
module refill_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [9:0]        req0_blk,
  input  logic              req1,
  input  logic [9:0]        req1_blk,
  output logic [1:0]        gnt,
  output logic              busy,
  output logic              mem_en,
  output logic [11:0]       mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rfl_valid,
  output logic              rfl_id,
  output logic [1:0]        rfl_word,
  output logic [DATA_W-1:0] rfl_data,
  output logic              rfl_last,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [9:0]  blk;
  logic        id;
  logic        prio;
  logic [1:0]  cnt;
  logic [2:0]  lat;
  logic        win;
  logic        win_id;
  logic        capture;

  always_comb begin
    state_nxt = state;
    win       = 1'b0;
    win_id    = 1'b0;
    mem_en    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          win       = 1'b1;
          // A tie goes to the pointer; otherwise the lone requester wins.
          win_id    = (req0 && req1) ? prio : req1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        mem_en    = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (lat == 3'd1) begin
          capture   = 1'b1;
          state_nxt = (cnt == 2'd3) ? DONE : ISSUE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign mem_addr  = mem_en ? {blk, cnt} : 12'd0;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      blk       <= '0;
      id        <= 1'b0;
      prio      <= 1'b0;
      cnt       <= '0;
      lat       <= '0;
      gnt       <= '0;
      rfl_valid <= 1'b0;
      rfl_id    <= 1'b0;
      rfl_word  <= '0;
      rfl_data  <= '0;
      rfl_last  <= 1'b0;
    end else begin
      state     <= state_nxt;
      rfl_valid <= 1'b0;
      rfl_last  <= 1'b0;
      if (win) begin
        blk <= win_id ? req1_blk : req0_blk;
        id  <= win_id;
        cnt <= '0;
        gnt <= win_id ? 2'b10 : 2'b01;
      end
      if (state == ISSUE) lat <= 3'(MEM_LAT);
      if (state == WAIT)  lat <= lat - 3'd1;
      if (capture) begin
        rfl_valid <= 1'b1;
        rfl_id    <= id;
        rfl_word  <= cnt;
        rfl_data  <= mem_rdata;
        rfl_last  <= (cnt == 2'd3);
        if (cnt != 2'd3) cnt <= cnt + 2'd1;
      end
      // Hand priority to the other side so a lingering request cannot starve it.
      if (state == DONE) begin
        prio <= ~id;
        gnt  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_refill_arbiter.sv
// Bench for refill_arbiter: one instance with MEM_LAT=2 and one with MEM_LAT=1,
// each checked every cycle against a timing-formula reference model.
module tb_refill_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_s [2];
  logic        req1_s [2];
  logic [9:0]  blk0_s [2];
  logic [9:0]  blk1_s [2];
  logic [1:0]  gnt_s [2];
  logic        busy_s [2];
  logic        mem_en_s [2];
  logic [11:0] mem_addr_s [2];
  logic [31:0] rdata_s [2];
  logic        rv_s [2];
  logic        rid_s [2];
  logic [1:0]  rword_s [2];
  logic [31:0] rdata_o [2];
  logic        rlast_s [2];
  logic [1:0]  dbg_s [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  refill_arbiter #(.MEM_LAT(2), .DATA_W(32)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .req0(req0_s[0]), .req0_blk(blk0_s[0]), .req1(req1_s[0]), .req1_blk(blk1_s[0]),
    .gnt(gnt_s[0]), .busy(busy_s[0]), .mem_en(mem_en_s[0]), .mem_addr(mem_addr_s[0]),
    .mem_rdata(rdata_s[0]), .rfl_valid(rv_s[0]), .rfl_id(rid_s[0]), .rfl_word(rword_s[0]),
    .rfl_data(rdata_o[0]), .rfl_last(rlast_s[0]), .dbg_state(dbg_s[0])
  );

  refill_arbiter #(.MEM_LAT(1), .DATA_W(32)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req0(req0_s[1]), .req0_blk(blk0_s[1]), .req1(req1_s[1]), .req1_blk(blk1_s[1]),
    .gnt(gnt_s[1]), .busy(busy_s[1]), .mem_en(mem_en_s[1]), .mem_addr(mem_addr_s[1]),
    .mem_rdata(rdata_s[1]), .rfl_valid(rv_s[1]), .rfl_id(rid_s[1]), .rfl_word(rword_s[1]),
    .rfl_data(rdata_o[1]), .rfl_last(rlast_s[1]), .dbg_state(dbg_s[1])
  );

  // Memories: data = A000_0000 | addr exactly MEM_LAT cycles after the strobe, noise otherwise.
  logic        pv2 [2] = '{1'b0, 1'b0};
  logic [11:0] pa2 [2];
  logic        pv1 = 1'b0;
  logic [11:0] pa1;
  logic [31:0] noise2 = 32'd0;
  logic [31:0] noise1 = 32'd0;

  always @(posedge clk) begin
    pv2[0] <= mem_en_s[0];
    pa2[0] <= mem_addr_s[0];
    pv2[1] <= pv2[0];
    pa2[1] <= pa2[0];
    pv1    <= mem_en_s[1];
    pa1    <= mem_addr_s[1];
    noise2 <= $urandom;
    noise1 <= $urandom;
  end

  assign rdata_s[0] = pv2[1] ? (32'hA000_0000 | {20'd0, pa2[1]}) : noise2;
  assign rdata_s[1] = pv1    ? (32'hA000_0000 | {20'd0, pa1})    : noise1;

  // Requester behaviour and reference model state.
  bit        rst_v;
  bit        want  [2][2];
  bit        rerun [2][2];
  bit        drop  [2][2];
  bit [9:0]  blk_v [2][2];
  int        lat_c [2] = '{2, 1};
  bit        act   [2];
  int        mstart[2];
  bit [9:0]  mblk  [2];
  bit        mid   [2];
  bit        mprio [2];
  int        cyc = 0;
  bit        collect = 1'b0;
  logic [0:0] got_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s c%0d: observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit in_burst(input int i);
    return act[i] && (cyc <= mstart[i] + 4 * (lat_c[i] + 1) + 1);
  endfunction

  task automatic step();
    int p, r, w;
    logic [1:0]  e_gnt;
    logic        e_busy, e_en, e_v, e_last;
    logic [11:0] e_addr;
    logic [1:0]  e_word;
    logic [31:0] e_data;
    @(negedge clk);
    rst_n = rst_v;
    for (int i = 0; i < 2; i++) begin
      req0_s[i] = want[i][0] && !drop[i][0];
      req1_s[i] = want[i][1] && !drop[i][1];
      blk0_s[i] = blk_v[i][0];
      blk1_s[i] = blk_v[i][1];
      drop[i][0] = 1'b0;
      drop[i][1] = 1'b0;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      if (!rst_v) begin
        act[i]   = 1'b0;
        mprio[i] = 1'b0;
      end
      p = lat_c[i] + 1;
      r = cyc - mstart[i];
      e_gnt = 2'b00; e_busy = 1'b0; e_en = 1'b0; e_addr = 12'd0;
      e_v = 1'b0; e_word = 2'd0; e_data = 32'd0; e_last = 1'b0;
      if (act[i] && r >= 1 && r <= 4 * p + 1) begin
        e_gnt  = mid[i] ? 2'b10 : 2'b01;
        e_busy = 1'b1;
        if ((r - 1) % p == 0 && (r - 1) / p <= 3) begin
          e_en   = 1'b1;
          e_addr = {mblk[i], 2'((r - 1) / p)};
        end
        if (r >= p + 1 && (r - 1 - p) % p == 0) begin
          w      = (r - 1 - p) / p;
          e_v    = 1'b1;
          e_word = 2'(w);
          e_data = 32'hA000_0000 | {20'd0, mblk[i], 2'(w)};
          e_last = (w == 3);
        end
      end
      chk($sformatf("u%0d gnt", i), {30'd0, gnt_s[i]}, {30'd0, e_gnt});
      chk($sformatf("u%0d busy", i), {31'd0, busy_s[i]}, {31'd0, e_busy});
      chk($sformatf("u%0d mem_en", i), {31'd0, mem_en_s[i]}, {31'd0, e_en});
      chk($sformatf("u%0d mem_addr", i), {20'd0, mem_addr_s[i]}, {20'd0, e_addr});
      chk($sformatf("u%0d rfl_valid", i), {31'd0, rv_s[i]}, {31'd0, e_v});
      chk($sformatf("u%0d rfl_last", i), {31'd0, rlast_s[i]}, {31'd0, e_last});
      if (e_v || !rst_v) begin
        chk($sformatf("u%0d rfl_id", i), {31'd0, rid_s[i]}, {31'd0, e_v ? mid[i] : 1'b0});
        chk($sformatf("u%0d rfl_word", i), {30'd0, rword_s[i]}, {30'd0, e_word});
        chk($sformatf("u%0d rfl_data", i), rdata_o[i], e_data);
      end
      if (rlast_s[i]) begin
        drop[i][rid_s[i]] = 1'b1;
        if (!rerun[i][rid_s[i]]) want[i][rid_s[i]] = 1'b0;
        if (collect && i == 0) got_q.push_back(rid_s[i]);
      end
      if (rst_v && !in_burst(i) && (req0_s[i] || req1_s[i])) begin
        act[i]    = 1'b1;
        mstart[i] = cyc;
        mid[i]    = (req0_s[i] && req1_s[i]) ? mprio[i] : req1_s[i];
        mblk[i]   = mid[i] ? blk1_s[i] : blk0_s[i];
        mprio[i]  = ~mid[i];
      end
    end
    cyc++;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while ((in_burst(0) || in_burst(1) || want[0][0] || want[0][1] || want[1][0] || want[1][1])
           && n < limit) begin
      step();
      n++;
    end
    checks++;
    if (n >= limit) begin
      errors++;
      $display("FAIL wait_idle: observed timeout after %0d cycles, required idle", n);
    end
    step();
  endtask

  task automatic set_req(input int i, input int n, input bit [9:0] b, input bit rr);
    want[i][n]  = 1'b1;
    blk_v[i][n] = b;
    rerun[i][n] = rr;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      req0_s[i] = 1'b0; req1_s[i] = 1'b0; blk0_s[i] = '0; blk1_s[i] = '0;
      act[i] = 1'b0; mprio[i] = 1'b0; mstart[i] = 0;
    end
    // Reset with both requests high; after release req0 wins the tie, req1 follows.
    rst_v = 1'b0;
    set_req(0, 0, 10'h001, 1'b0);
    set_req(0, 1, 10'h3FF, 1'b0);
    repeat (4) step();
    rst_v = 1'b1;
    wait_idle(200);

    // Single burst at MEM_LAT=2 alongside a MEM_LAT=1 burst from requester 1.
    set_req(0, 0, 10'h005, 1'b0);
    set_req(1, 1, 10'h002, 1'b0);
    wait_idle(200);

    // Reset pulse in cycle 6 of a burst; the held request restarts at word 0.
    set_req(0, 0, 10'h005, 1'b0);
    n = 0;
    while (!in_burst(0) && n < 20) begin
      step();
      n++;
    end
    repeat (5) step();
    rst_v = 1'b0;
    step();
    rst_v = 1'b1;
    wait_idle(200);

    // Fairness from a fresh reset: both requesters keep asking.
    rst_v = 1'b0;
    step();
    rst_v = 1'b1;
    got_q.delete();
    collect = 1'b1;
    set_req(0, 0, 10'h0A0, 1'b1);
    set_req(0, 1, 10'h0B0, 1'b1);
    n = 0;
    while (got_q.size() < 6 && n < 200) begin
      step();
      n++;
    end
    collect = 1'b0;
    for (int k = 0; k < 2; k++) begin
      want[0][k]  = 1'b0;
      rerun[0][k] = 1'b0;
    end
    chk("fair count", 32'(got_q.size()), 32'd6);
    for (int k = 0; k < got_q.size() && k < 6; k++)
      chk($sformatf("fair id%0d", k), {31'd0, got_q[k]}, 32'(k % 2));
    wait_idle(200);

    // Random traffic on both instances.
    for (int t = 0; t < 600; t++) begin
      for (int i = 0; i < 2; i++)
        for (int k = 0; k < 2; k++)
          if (!want[i][k] && $urandom_range(0, 5) == 0)
            set_req(i, k, 10'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)));
      step();
    end
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 2; k++)
        rerun[i][k] = 1'b0;
    wait_idle(300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
